// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC custom instruction: range-checks the angle,
// walks the micro-rotation stage through load/iterate/drain and returns its result.
module cordic_seq_ctrl #(
    parameter int          WIDTH      = 22,
    parameter int          ITERS      = 22,
    parameter int          DRAIN_CYC  = 2,
    parameter int          MAX_ANGLE  = 1 << WIDTH,
    parameter logic [31:0] ERR_RESULT = 32'h7fc00000,
    localparam int         IW         = (ITERS > 1) ? $clog2(ITERS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH+1:0] angle_in,
    input  logic [31:0]      dp_result,
    output logic             dp_load,
    output logic             dp_en,
    output logic [IW-1:0]    dp_iter,
    output logic [WIDTH+1:0] dp_angle,
    output logic [31:0]      result,
    output logic             done,
    output logic             busy,
    output logic             range_err
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [WIDTH+1:0] MAXA     = (WIDTH+2)'(MAX_ANGLE);
    localparam logic [WIDTH+1:0] MOST_NEG = {1'b1, {(WIDTH+1){1'b0}}};
    localparam logic [IW-1:0]    ITER_END = IW'(ITERS - 1);
    localparam logic [DW-1:0]    DRN_END  = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic [WIDTH+1:0] angle_q, angle_d;
    logic [31:0]      result_q, result_d;
    logic             rerr_q, rerr_d;

    logic [WIDTH+1:0] mag;
    logic             in_range;

    // Most negative code negates to itself; excluded explicitly rather than trusting abs.
    assign mag      = angle_in[WIDTH+1] ? -angle_in : angle_in;
    assign in_range = (angle_in != MOST_NEG) && (mag <= MAXA);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        angle_d  = angle_q;
        result_d = result_q;
        rerr_d   = rerr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    angle_d = angle_in;
                    rerr_d  = 1'b0;
                    if (in_range) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d  = S_DONE;
                        result_d = ERR_RESULT;
                        rerr_d   = 1'b1;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (cnt_q == ITER_END) begin
                    if (DRAIN_CYC == 0) begin
                        state_d  = S_DONE;
                        result_d = dp_result;
                    end else begin
                        state_d = S_DRAIN;
                        drn_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_END) begin
                    state_d  = S_DONE;
                    result_d = dp_result;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            drn_q    <= '0;
            angle_q  <= '0;
            result_q <= '0;
            rerr_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drn_q    <= drn_d;
            angle_q  <= angle_d;
            result_q <= result_d;
            rerr_q   <= rerr_d;
        end
    end

    assign dp_load   = (state_q == S_LOAD);
    assign dp_en     = (state_q == S_ITER);
    assign dp_iter   = (state_q == S_ITER) ? cnt_q : '0;
    assign dp_angle  = angle_q;
    assign result    = result_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_DRAIN);
    assign range_err = rerr_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: cycle-exact timing of accepted, rejected,
// stalled, back-to-back and reset-interrupted operations at default parameters.
module tb_cordic_seq_ctrl;

    localparam logic [31:0] DP_RES = 32'h3f000000;
    localparam logic [31:0] ERR    = 32'h7fc00000;

    logic        clk = 1'b0;
    logic        reset_n, clk_en, start;
    logic [23:0] angle_in;
    logic [31:0] dp_result;
    logic        dp_load, dp_en, done, busy, range_err;
    logic [4:0]  dp_iter;
    logic [23:0] dp_angle;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
        .angle_in(angle_in), .dp_result(dp_result),
        .dp_load(dp_load), .dp_en(dp_en), .dp_iter(dp_iter), .dp_angle(dp_angle),
        .result(result), .done(done), .busy(busy), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs e effective cycles after the start was sampled.
    task automatic chk_cycle(input int e, input bit acc, input logic [23:0] ang);
        int  last = acc ? 26 : 1;
        bit  en   = acc && e >= 2 && e <= 23;
        chk($sformatf("dp_load e=%0d", e), {31'd0, dp_load}, {31'd0, acc && e == 1});
        chk($sformatf("dp_en e=%0d", e),   {31'd0, dp_en},   {31'd0, en});
        chk($sformatf("dp_iter e=%0d", e), {27'd0, dp_iter}, en ? e - 2 : 0);
        chk($sformatf("busy e=%0d", e),    {31'd0, busy},    {31'd0, acc && e >= 1 && e <= 25});
        chk($sformatf("done e=%0d", e),    {31'd0, done},    {31'd0, e == last});
        if (e >= 1) begin
            chk($sformatf("dp_angle e=%0d", e),  {8'd0, dp_angle},   {8'd0, ang});
            chk($sformatf("range_err e=%0d", e), {31'd0, range_err}, {31'd0, !acc});
        end
        if (e >= last)
            chk($sformatf("result e=%0d", e), result, acc ? DP_RES : ERR);
    endtask

    // One operation starting in the current cycle. Stall windows are given in raw
    // cycles since start; chain returns in the done cycle so the next op starts there.
    task automatic op(input logic [23:0] ang, input bit acc, input bit hold, input bit chain,
                      input int s1, input int l1, input int s2, input int l2);
        int e    = 0;
        int last = acc ? 26 : 1;
        bit adv;
        start    = 1'b1;
        angle_in = ang;
        for (int t = 1; t < 100; t++) begin
            adv = clk_en;
            step();
            if (adv) e++;
            if (e >= 1) begin
                if (!hold) start = 1'b0;
                angle_in = 24'h123456;
            end
            clk_en = !((t >= s1 && t < s1 + l1) || (t >= s2 && t < s2 + l2));
            chk_cycle(e, acc, ang);
            if (chain && e == last && clk_en) return;
            if (e == last + 1) return;
        end
        chk("op timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        clk_en    = 1'b1;
        start     = 1'b0;
        angle_in  = 24'h0;
        dp_result = DP_RES;
        step();
        step();
        chk("rst dp_load", {31'd0, dp_load}, 0);
        chk("rst dp_en", {31'd0, dp_en}, 0);
        chk("rst dp_iter", {27'd0, dp_iter}, 0);
        chk("rst dp_angle", {8'd0, dp_angle}, 0);
        chk("rst result", result, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst range_err", {31'd0, range_err}, 0);
        #4 reset_n = 1'b1;
        step();

        op(24'h400000, 1, 0, 0, 0, 0, 0, 0);
        op(24'hC00000, 1, 0, 0, 0, 0, 0, 0);
        op(24'h000000, 1, 0, 0, 0, 0, 0, 0);
        op(24'h400001, 0, 0, 0, 0, 0, 0, 0);
        op(24'h800000, 0, 0, 0, 0, 0, 0, 0);
        op(24'hBFFFFF, 0, 0, 0, 0, 0, 0, 0);
        // Stall 5 cycles mid-ITER, then 3 cycles while in DONE.
        op(24'h400000, 1, 0, 0, 10, 5, 31, 3);
        // Start held high: ignored while busy, re-accepted in each DONE cycle.
        op(24'h400000, 1, 1, 1, 0, 0, 0, 0);
        op(24'h800000, 0, 1, 1, 0, 0, 0, 0);
        op(24'hC00000, 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset at dp_iter=10.
        start    = 1'b1;
        angle_in = 24'h400000;
        begin
            int g = 0;
            while (!(dp_en && dp_iter == 5'd10) && g < 40) begin
                step();
                start = 1'b0;
                g++;
            end
            chk("reach iter10", {31'd0, dp_en && dp_iter == 5'd10}, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("arst dp_load", {31'd0, dp_load}, 0);
        chk("arst dp_en", {31'd0, dp_en}, 0);
        chk("arst dp_iter", {27'd0, dp_iter}, 0);
        chk("arst dp_angle", {8'd0, dp_angle}, 0);
        chk("arst result", result, 0);
        chk("arst done", {31'd0, done}, 0);
        chk("arst busy", {31'd0, busy}, 0);
        chk("arst range_err", {31'd0, range_err}, 0);
        step();
        chk("arst hold done", {31'd0, done}, 0);
        @(posedge clk);
        #5 reset_n = 1'b1;
        step();
        op(24'h000001, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
